hive_irq_ctrl: RTL and testbench
================================

// Module: hive_irq_ctrl
// PURPOSE
// - Per-thread interrupt and clear scheduler for the 8-thread barrel core; sits directly upstream of the PC ring.
// - Captures external interrupt and thread-clear events, holds them pending per thread, and
//   asserts clt_o / irq_o to the PC ring when the owning thread's slot (id_i) comes round at stage 0.
// - Tracks per-thread in-service state so interrupts do not nest; cleared by irt from the pipeline.
// PARAMETERS
// - THREADS  8  number of hardware threads (ring slots)
// - ID_W     3  thread id width, clog2(THREADS)
// PORTS
// - clk_i        in   1        clock
// - rst_i        in   1        reset, synchronous, active high
// - id_i         in   ID_W     thread id currently at ring stage 0 (increments mod THREADS each cycle)
// - irq_req_i    in   THREADS  interrupt request levels, already synchronized to clk_i
// - clt_req_i    in   THREADS  thread clear request levels, already synchronized to clk_i
// - en_wr_i      in   1        1 : load enable mask from en_i
// - en_i         in   THREADS  new interrupt enable mask
// - irt_i        in   1        1 : return-from-interrupt retired for thread irt_id_i
// - irt_id_i     in   ID_W     thread id of the irt
// - clt_o        out  1        1 : clear PC of thread id_i (to PC ring clt_i)
// - irq_o        out  1        1 : vector thread id_i to interrupt (to PC ring irq_i)
// - en_o         out  THREADS  current enable mask
// - pend_o       out  THREADS  interrupt pending flags
// - isr_o        out  THREADS  in-service flags
// BEHAVIOUR
// - State regs (all THREADS wide): irq_prev, clt_prev, en, pend, clt_pend, isr.
// - Reset (sync, dominates everything): all state regs 0; clt_o=0, irq_o=0, en_o=0, pend_o=0, isr_o=0.
// - Edge detect: irq_edge = irq_req_i & ~irq_prev; clt_edge = clt_req_i & ~clt_prev; prev regs load inputs each cycle.
// - Levels held high create one event only; a new event requires a low-then-high transition.
// - clt_o = clt_pend[id_i] (combinational from registered state and id_i; zero added latency).
// - irq_o = pend[id_i] & en[id_i] & ~isr[id_i] & ~clt_pend[id_i].
// - Priority per slot: clear > interrupt. clt_o and irq_o are never both 1.
// - Per-thread update each edge, for thread t:
//   - clt_pend[t]: set on clt_edge[t]; else cleared when clt_o for id_i==t.
//   - Serviced clear also clears pend[t] and isr[t] (thread restarts clean); en[t] unchanged.
//   - pend[t]: set on irq_edge[t] & en[t]; else cleared when irq_o for id_i==t or serviced clear.
//   - isr[t]: set when irq_o for id_i==t; cleared on irt_i & irt_id_i==t or serviced clear.
// - Simultaneous events:
//   - Event edge and service in the same cycle: the edge wins; flag stays 1 (re-queued, not lost).
//   - irq service and irt on the same thread in one cycle cannot occur legally (isr blocks irq).
//     If forced, set wins.
// - Edge of an irq while en[t]=0: dropped, not stored.
// - Disabling a thread with pend=1: pend held, irq_o masked; re-enabling releases it.
// - en_wr_i: en <= en_i at the edge. The new mask gates irq edges from the following cycle.
// - irt_i with isr[irt_id_i]=0: ignored, no error.
// - Each thread is serviced at most once per ring revolution (THREADS cycles).
// - Worst-case latency from event edge to clt_o/irq_o: THREADS cycles.
// - Reset mid-operation: all pending/in-service state discarded.
//   Edges present at reset deassert are detected on the next cycle (prev=0).
// TESTING
// - Reset, then irq_req_i[3]=1 with en=8'h08.
//   -> pend_o[3]=1 next cycle; irq_o=1 exactly when id_i==3; then pend_o[3]=0, isr_o[3]=1.
// - While isr_o[3]=1, toggle irq_req_i[3] 0->1.
//   -> pend_o[3]=1 but irq_o stays 0 at id_i==3.
//   After irt_i with irt_id_i=3: irq_o=1 on the next id_i==3 slot.
// - clt_req_i[5] and irq_req_i[5] rise together, en=8'hFF.
//   -> at id_i==5: clt_o=1, irq_o=0.
//   Afterwards pend_o[5]=0, isr_o[5]=0, and no irq_o on later slots for thread 5.
// - irq_req_i[1] rises with en=0.
//   -> pend_o stays 0; later write en_i=8'h02 -> still no irq_o (event dropped).
// - irq_req_i[2] edge in the exact cycle id_i==2 services an earlier pending irq.
//   -> irq_o=1 that cycle and pend_o[2] remains 1; irq_o reasserts after irt.
// - Assert rst_i while pend_o=8'hAA, isr_o=8'h55.
//   -> next cycle all outputs 0; held-high requests produce events after reset release.

Source files
------------

// File: rtl/hive_irq_ctrl.sv
// Per-thread interrupt / thread-clear scheduler for the 8-thread barrel core.
// Events are held pending per thread and presented to the PC ring when the owning slot reaches stage 0.
module hive_irq_ctrl #(
    parameter int THREADS = 8,
    parameter int ID_W    = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [ID_W-1:0]    id_i,
    input  logic [THREADS-1:0] irq_req_i,
    input  logic [THREADS-1:0] clt_req_i,
    input  logic               en_wr_i,
    input  logic [THREADS-1:0] en_i,
    input  logic               irt_i,
    input  logic [ID_W-1:0]    irt_id_i,
    output logic               clt_o,
    output logic               irq_o,
    output logic [THREADS-1:0] en_o,
    output logic [THREADS-1:0] pend_o,
    output logic [THREADS-1:0] isr_o
);

    logic [THREADS-1:0] irq_prev_q, irq_prev_d;
    logic [THREADS-1:0] clt_prev_q, clt_prev_d;
    logic [THREADS-1:0] en_q, en_d;
    logic [THREADS-1:0] pend_q, pend_d;
    logic [THREADS-1:0] clt_pend_q, clt_pend_d;
    logic [THREADS-1:0] isr_q, isr_d;

    logic [THREADS-1:0] irq_edge;
    logic [THREADS-1:0] clt_edge;
    logic [THREADS-1:0] slot_sel;
    logic [THREADS-1:0] irt_sel;
    logic [THREADS-1:0] svc_clt;
    logic [THREADS-1:0] svc_irq;

    // Clear outranks interrupt on the same slot, so irq_o is masked by a pending clear.
    assign clt_o  = clt_pend_q[id_i];
    assign irq_o  = pend_q[id_i] & en_q[id_i] & ~isr_q[id_i] & ~clt_pend_q[id_i];
    assign en_o   = en_q;
    assign pend_o = pend_q;
    assign isr_o  = isr_q;

    assign irq_edge = irq_req_i & ~irq_prev_q;
    assign clt_edge = clt_req_i & ~clt_prev_q;

    always_comb begin
        slot_sel           = '0;
        slot_sel[id_i]     = 1'b1;
        irt_sel            = '0;
        irt_sel[irt_id_i]  = irt_i;
    end

    assign svc_clt = slot_sel & {THREADS{clt_o}};
    assign svc_irq = slot_sel & {THREADS{irq_o}};

    // New edges are OR-ed in after the service terms so an edge arriving in its own service cycle is re-queued.
    always_comb begin
        irq_prev_d = irq_req_i;
        clt_prev_d = clt_req_i;
        en_d       = en_wr_i ? en_i : en_q;
        clt_pend_d = clt_edge | (clt_pend_q & ~svc_clt);
        pend_d     = (irq_edge & en_q) | (pend_q & ~svc_irq & ~svc_clt);
        isr_d      = svc_irq | (isr_q & ~irt_sel & ~svc_clt);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_prev_q <= '0;
            clt_prev_q <= '0;
            en_q       <= '0;
            pend_q     <= '0;
            clt_pend_q <= '0;
            isr_q      <= '0;
        end else begin
            irq_prev_q <= irq_prev_d;
            clt_prev_q <= clt_prev_d;
            en_q       <= en_d;
            pend_q     <= pend_d;
            clt_pend_q <= clt_pend_d;
            isr_q      <= isr_d;
        end
    end

endmodule

// File: tb/tb_hive_irq_ctrl.sv
// Directed bench for hive_irq_ctrl: the bench drives the ring slot id and checks outputs
// against hand-computed values two time units after each rising edge.
module tb_hive_irq_ctrl;

    logic       clk_i;
    logic       rst_i;
    logic [2:0] id_i;
    logic [7:0] irq_req_i;
    logic [7:0] clt_req_i;
    logic       en_wr_i;
    logic [7:0] en_i;
    logic       irt_i;
    logic [2:0] irt_id_i;
    logic       clt_o;
    logic       irq_o;
    logic [7:0] en_o;
    logic [7:0] pend_o;
    logic [7:0] isr_o;

    int compareCount;
    int mismatchCount;

    hive_irq_ctrl #(.THREADS(8), .ID_W(3)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .id_i      (id_i),
        .irq_req_i (irq_req_i),
        .clt_req_i (clt_req_i),
        .en_wr_i   (en_wr_i),
        .en_i      (en_i),
        .irt_i     (irt_i),
        .irt_id_i  (irt_id_i),
        .clt_o     (clt_o),
        .irq_o     (irq_o),
        .en_o      (en_o),
        .pend_o    (pend_o),
        .isr_o     (isr_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Single comparison point; every check goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
        end
    endtask

    // One clock: the ring slot advances right after the edge, outputs settle before sampling.
    task automatic applyStimulus();
        @(posedge clk_i);
        #1;
        id_i = id_i + 3'd1;
        #1;
    endtask

    task automatic goToSlot(input logic [2:0] slot);
        for (int k = 0; k < 8; k++) begin
            if (id_i == slot) break;
            applyStimulus();
        end
    endtask

    task automatic writeEnable(input logic [7:0] mask);
        en_wr_i = 1'b1;
        en_i    = mask;
        applyStimulus();
        en_wr_i = 1'b0;
    endtask

    task automatic retire(input logic [2:0] tid);
        irt_i    = 1'b1;
        irt_id_i = tid;
        applyStimulus();
        irt_i    = 1'b0;
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        rst_i     = 1'b1;
        id_i      = 3'd0;
        irq_req_i = '0;
        clt_req_i = '0;
        en_wr_i   = 1'b0;
        en_i      = '0;
        irt_i     = 1'b0;
        irt_id_i  = '0;

        // Reset state
        applyStimulus();
        applyStimulus();
        checkOutput("rst_clt", clt_o, 0);
        checkOutput("rst_irq", irq_o, 0);
        checkOutput("rst_en", en_o, 0);
        checkOutput("rst_pend", pend_o, 0);
        checkOutput("rst_isr", isr_o, 0);
        rst_i = 1'b0;

        // Basic interrupt on thread 3
        writeEnable(8'h08);
        checkOutput("t1_en", en_o, 8'h08);
        goToSlot(3'd0);
        irq_req_i[3] = 1'b1;
        applyStimulus();
        checkOutput("t1_pend", pend_o, 8'h08);
        checkOutput("t1_irq_off_slot", irq_o, 0);
        goToSlot(3'd3);
        checkOutput("t1_irq_slot3", irq_o, 1);
        checkOutput("t1_clt_slot3", clt_o, 0);
        applyStimulus();
        checkOutput("t1_pend_after", pend_o, 8'h00);
        checkOutput("t1_isr_after", isr_o, 8'h08);
        checkOutput("t1_irq_slot4", irq_o, 0);

        // No nesting while in service; irt releases the queued event
        irq_req_i[3] = 1'b0;
        applyStimulus();
        irq_req_i[3] = 1'b1;
        applyStimulus();
        checkOutput("t2_pend", pend_o, 8'h08);
        goToSlot(3'd3);
        checkOutput("t2_irq_blocked", irq_o, 0);
        retire(3'd3);
        checkOutput("t2_isr_clr", isr_o, 8'h00);
        goToSlot(3'd3);
        checkOutput("t2_irq_after_irt", irq_o, 1);
        applyStimulus();
        checkOutput("t2_isr_set", isr_o, 8'h08);
        retire(3'd3);
        checkOutput("t2_isr_clean", isr_o, 8'h00);

        // Clear beats interrupt on thread 5
        writeEnable(8'hFF);
        goToSlot(3'd0);
        clt_req_i[5] = 1'b1;
        irq_req_i[5] = 1'b1;
        applyStimulus();
        checkOutput("t3_pend", pend_o, 8'h20);
        goToSlot(3'd5);
        checkOutput("t3_clt", clt_o, 1);
        checkOutput("t3_irq", irq_o, 0);
        applyStimulus();
        checkOutput("t3_pend_after", pend_o, 8'h00);
        checkOutput("t3_isr_after", isr_o, 8'h00);
        goToSlot(3'd5);
        checkOutput("t3_clt_later", clt_o, 0);
        checkOutput("t3_irq_later", irq_o, 0);

        // Edge while disabled is dropped
        writeEnable(8'h00);
        irq_req_i[1] = 1'b1;
        applyStimulus();
        checkOutput("t4_pend", pend_o, 8'h00);
        writeEnable(8'h02);
        goToSlot(3'd1);
        checkOutput("t4_irq", irq_o, 0);
        checkOutput("t4_pend_after_en", pend_o, 8'h00);

        // Edge arriving in the service cycle is re-queued
        writeEnable(8'h04);
        goToSlot(3'd0);
        irq_req_i[2] = 1'b1;
        applyStimulus();
        irq_req_i[2] = 1'b0;
        checkOutput("t5_pend", pend_o, 8'h04);
        goToSlot(3'd2);
        checkOutput("t5_irq_service", irq_o, 1);
        irq_req_i[2] = 1'b1;
        applyStimulus();
        checkOutput("t5_pend_kept", pend_o, 8'h04);
        checkOutput("t5_isr", isr_o, 8'h04);
        goToSlot(3'd2);
        checkOutput("t5_irq_blocked", irq_o, 0);
        retire(3'd2);
        goToSlot(3'd2);
        checkOutput("t5_irq_reassert", irq_o, 1);
        applyStimulus();
        retire(3'd2);
        checkOutput("t5_clean_pend", pend_o, 8'h00);
        checkOutput("t5_clean_isr", isr_o, 8'h00);

        // Build pend=AA / isr=55, then reset mid-operation
        irq_req_i = 8'h00;
        clt_req_i = 8'h00;
        applyStimulus();
        writeEnable(8'hFF);
        irq_req_i = 8'h55;
        for (int k = 0; k < 9; k++) applyStimulus();
        checkOutput("t6_isr55", isr_o, 8'h55);
        checkOutput("t6_pend0", pend_o, 8'h00);
        irq_req_i = 8'hFF;
        writeEnable(8'h55);
        checkOutput("t6_pendAA", pend_o, 8'hAA);
        checkOutput("t6_isr55b", isr_o, 8'h55);
        checkOutput("t6_en55", en_o, 8'h55);
        checkOutput("t6_irq_masked", irq_o, 0);
        rst_i     = 1'b1;
        clt_req_i = 8'h01;
        applyStimulus();
        checkOutput("t6_rst_pend", pend_o, 0);
        checkOutput("t6_rst_isr", isr_o, 0);
        checkOutput("t6_rst_en", en_o, 0);
        checkOutput("t6_rst_clt", clt_o, 0);
        checkOutput("t6_rst_irq", irq_o, 0);
        rst_i = 1'b0;
        applyStimulus();
        goToSlot(3'd0);
        checkOutput("t6_held_clt", clt_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
